// File: rtl/setup_ht_coeff.sv
// Streams the fixed 27-tap Hilbert-transform coefficient set, one per clock, then
// raises coeffSetFlag. Dropping enable returns to IDLE so that a later enable restarts at c[0].
module setup_ht_coeff #(
  parameter int LENGTH     = 27,
  parameter int DATA_WIDTH = 18
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  output logic                         coeffSetFlag,
  output logic signed [DATA_WIDTH-1:0] coeffOut,
  output logic [1:0]                   o_state
);

  localparam int IW = $clog2(LENGTH + 1);
  localparam logic [IW-1:0] LEN_C = IW'(LENGTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [IW-1:0]                 r_idx, w_idx_nxt;
  logic signed [DATA_WIDTH-1:0]  r_coeff, w_coeff_nxt;
  logic                          r_flag, w_flag_nxt;

  // Antisymmetric table: c[26-i] = -c[i]. Every odd index and the centre tap are zero.
  function automatic logic signed [DATA_WIDTH-1:0] rom_lookup(input logic [IW-1:0] i);
    int v;
    v = 0;
    case (int'(i))
      0:  v = -25;
      2:  v = -51;
      4:  v = -100;
      6:  v = -181;
      8:  v = -321;
      10: v = -624;
      12: v = -2018;
      14: v = 2018;
      16: v = 624;
      18: v = 321;
      20: v = 181;
      22: v = 100;
      24: v = 51;
      26: v = 25;
      default: v = 0;
    endcase
    return DATA_WIDTH'(v);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_coeff <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_coeff <= w_coeff_nxt;
      r_flag  <= w_flag_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_coeff_nxt = r_coeff;
    w_flag_nxt  = r_flag;
    case (r_state)
      IDLE: begin
        w_idx_nxt   = '0;
        w_coeff_nxt = '0;
        w_flag_nxt  = 1'b0;
        if (enable) begin
          w_coeff_nxt = rom_lookup('0);
          w_idx_nxt   = IW'(1);
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_coeff_nxt = '0;
          w_flag_nxt  = 1'b0;
        end else if (r_idx < LEN_C) begin
          w_coeff_nxt = rom_lookup(r_idx);
          w_idx_nxt   = r_idx + IW'(1);
        end else begin
          w_coeff_nxt = '0;
          w_flag_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_coeff_nxt = '0;
        if (!enable) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_flag_nxt  = 1'b0;
        end else begin
          w_flag_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_coeff_nxt = '0;
        w_flag_nxt  = 1'b0;
      end
    endcase
  end

  assign coeffOut     = r_coeff;
  assign coeffSetFlag = r_flag;
  assign o_state      = r_state;

endmodule

// File: tb/tb_setup_ht_coeff.sv
// Scoreboard bench for setup_ht_coeff: the driver pushes the expected {flag, coeff} per
// clock and a negedge monitor pops and compares it against the registered outputs.
module tb_setup_ht_coeff;

  localparam int DW = 18;
  localparam int EW = 25;  // {cap_valid, cap_idx[4:0], flag, coeff[17:0]}

  logic                 clock;
  logic                 reset_n;
  logic                 enable;
  logic                 coeff_set_flag;
  logic signed [DW-1:0] coeff_out;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0]        exp_q[$];
  logic signed [DW-1:0] cap[27];

  int rom[27] = '{-25, 0, -51, 0, -100, 0, -181, 0, -321, 0, -624, 0, -2018, 0,
                  2018, 0, 624, 0, 321, 0, 181, 0, 100, 0, 51, 0, 25};

  setup_ht_coeff #(.LENGTH(27), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .coeffSetFlag (coeff_set_flag),
    .coeffOut     (coeff_out),
    .o_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)",
                  name, $signed(act), act, $signed(req), req);
  endtask

  // driver: one enabled/disabled edge, expected output after that edge
  task automatic step(input logic en, input logic f, input int c, input int cap_idx);
    enable = en;
    @(posedge clock);
    #1;
    exp_q.push_back({(cap_idx >= 0), 5'((cap_idx < 0) ? 0 : cap_idx), f, 18'(c)});
  endtask

  task automatic full_sequence(input logic do_capture);
    for (int k = 0; k < 27; k++) step(1'b1, 1'b0, rom[k], do_capture ? k : -1);
    step(1'b1, 1'b1, 0, -1);
  endtask

  task automatic drain();
    @(negedge clock);
    #1;
  endtask

  // monitor
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("coeff_out", 32'(coeff_out), 32'($signed(e[17:0])));
      check("coeff_set_flag", 32'(coeff_set_flag), 32'(e[18]));
      if (e[24]) cap[e[23:19]] = coeff_out;
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    #3;
    check("reset_coeff", 32'(coeff_out), 32'd0);
    check("reset_flag", 32'(coeff_set_flag), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    #9 reset_n = 1'b1;

    // idle with enable low
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, -1);

    // full stream, then hold in DONE
    full_sequence(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 0, -1);
    check("done_state", 32'(dbg_state), 32'd2);

    // back to idle, stream to c[8], drop enable, restart
    step(1'b0, 1'b0, 0, -1);
    for (int k = 0; k <= 8; k++) step(1'b1, 1'b0, rom[k], -1);
    step(1'b0, 1'b0, 0, -1);
    step(1'b0, 1'b0, 0, -1);
    full_sequence(1'b0);
    step(1'b1, 1'b1, 0, -1);

    // async reset mid-stream
    step(1'b0, 1'b0, 0, -1);
    for (int k = 0; k <= 4; k++) step(1'b1, 1'b0, rom[k], -1);
    drain();
    reset_n = 1'b0;
    #1;
    check("async_rst_coeff", 32'(coeff_out), 32'd0);
    check("async_rst_flag", 32'(coeff_set_flag), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'd0);
    step(1'b1, 1'b0, 0, -1);
    step(1'b1, 1'b0, 0, -1);
    reset_n = 1'b1;
    full_sequence(1'b0);
    step(1'b1, 1'b1, 0, -1);
    drain();
    drain();

    // antisymmetry on the captured first stream
    for (int i = 0; i < 13; i++)
      check($sformatf("antisym_%0d", i), 32'(cap[i] + cap[26 - i]), 32'd0);
    check("centre_tap", 32'(cap[13]), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule
